// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
    } fetch_rsp_t;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - redirect, imem and decode-side signals of the fetch queue
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_data_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            compressed_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, instr_ready_i,
        output imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, pc_o,
               compressed_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, instr_ready_i,
        input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, pc_o,
               compressed_o
    );

endinterface

// File: rtl/fetch_queue_hw_fifo.sv
// rtl/fetch_queue_hw_fifo.sv - circular halfword buffer, push 0/1/2 and pop 0/1/2 per cycle
module fetch_queue_hw_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic [1:0]             push_cnt,
    input  logic [15:0]            push_hw0,
    input  logic [15:0]            push_hw1,
    input  logic [1:0]             pop_cnt,
    output logic [15:0]            hw0,
    output logic [15:0]            hw1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_p1;
    logic [AW-1:0] rd_ptr_p1;

    assign wr_ptr_p1 = wr_ptr + AW'(1);
    assign rd_ptr_p1 = rd_ptr + AW'(1);
    assign hw0       = mem[rd_ptr];
    assign hw1       = mem[rd_ptr_p1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            wr_ptr <= wr_ptr + AW'(push_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // The popped slots are read combinationally before this edge, so a full queue may push and pop together
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_cnt != 2'd0) mem[wr_ptr] <= push_hw0;
            if (push_cnt == 2'd2) mem[wr_ptr_p1] <= push_hw1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !clear |-> (int'(count) + int'(push_cnt) - int'(pop_cnt)) <= DEPTH);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
        !clear |-> int'(pop_cnt) <= int'(count));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - decoupled RV32IC fetch: request credit, squash on redirect, 16/32-bit realignment
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH     = 8,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000
) (
    input logic           clk_i,
    input logic           rstn_i,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [OW-1:0]   outst;
    logic [OW-1:0]   drop;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] head_pc;
    logic            skip_lo;

    logic [15:0]     hw0;
    logic [15:0]     hw1;
    logic [CW-1:0]   count;
    fetch_rsp_t      rsp;

    logic            req_valid;
    logic            req_fire;
    logic            rsp_keep;
    logic            head_is32;
    logic            out_valid;
    logic            out_fire;
    logic [1:0]      push_cnt;
    logic [1:0]      pop_cnt;
    logic [15:0]     push_hw0;
    int              free_hw;
    int              need_hw;

    assign rsp.data = bus.imem_rsp_data_i;

    always_comb begin
        free_hw   = DEPTH - int'(count);
        need_hw   = 2 * (int'(outst) + 1);
        // Credit reserves room for every outstanding word, including ones that will be dropped
        req_valid = rstn_i && !bus.redirect_i && (int'(outst) < MAX_OUTST) && (free_hw >= need_hw);
        req_fire  = req_valid && bus.imem_req_ready_i;

        rsp_keep  = bus.imem_rsp_valid_i && !bus.redirect_i && (drop == '0);
        push_cnt  = 2'd0;
        push_hw0  = rsp.data[15:0];
        if (rsp_keep) begin
            push_cnt = skip_lo ? 2'd1 : 2'd2;
            push_hw0 = skip_lo ? rsp.data[31:16] : rsp.data[15:0];
        end

        head_is32 = !is_compressed(hw0);
        out_valid = !bus.redirect_i && (count != '0) && (!head_is32 || count >= CW'(2));
        out_fire  = out_valid && bus.instr_ready_i;
        pop_cnt   = 2'd0;
        if (out_fire) pop_cnt = head_is32 ? 2'd2 : 2'd1;
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = fetch_addr;
    assign bus.instr_valid_o    = out_valid;
    assign bus.instr_o          = !out_valid ? NOP_INSTR :
                                  head_is32  ? {hw1, hw0} : {16'h0000, hw0};
    assign bus.compressed_o     = out_valid && !head_is32;
    assign bus.pc_o             = head_pc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outst      <= '0;
            drop       <= '0;
            fetch_addr <= RESET_PC;
            head_pc    <= RESET_PC;
            skip_lo    <= 1'b0;
        end else begin
            outst <= outst + OW'(req_fire) - OW'(bus.imem_rsp_valid_i);
            if (bus.redirect_i) begin
                // Everything still in flight belongs to the old stream; the response landing now is discarded too
                drop       <= outst - OW'(bus.imem_rsp_valid_i);
                fetch_addr <= bus.redirect_pc_i & ~XLEN'(3);
                head_pc    <= bus.redirect_pc_i & ~XLEN'(1);
                skip_lo    <= bus.redirect_pc_i[1];
            end else begin
                if (bus.imem_rsp_valid_i && drop != '0) drop <= drop - OW'(1);
                if (rsp_keep) skip_lo <= 1'b0;
                if (req_fire) fetch_addr <= fetch_addr + XLEN'(4);
                if (out_fire) head_pc <= head_pc + (head_is32 ? XLEN'(4) : XLEN'(2));
            end
        end
    end

    fetch_queue_hw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rstn     (rstn_i),
        .clear    (bus.redirect_i),
        .push_cnt (push_cnt),
        .push_hw0 (push_hw0),
        .push_hw1 (rsp.data[31:16]),
        .pop_cnt  (pop_cnt),
        .hw0      (hw0),
        .hw1      (hw1),
        .count    (count)
    );

    a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rstn_i) count <= CW'(DEPTH));
    a_drop_le_outst:  assert property (@(posedge clk_i) disable iff (!rstn_i) drop <= outst);
    a_outst_le_max:   assert property (@(posedge clk_i) disable iff (!rstn_i) int'(outst) <= MAX_OUTST);
    a_rsp_expected:   assert property (@(posedge clk_i) disable iff (!rstn_i)
        bus.imem_rsp_valid_i |-> outst != '0);
    a_req_aligned:    assert property (@(posedge clk_i) disable iff (!rstn_i)
        bus.imem_req_valid_o |-> bus.imem_req_addr_o[1:0] == 2'b00);
    a_stall_stable:   assert property (@(posedge clk_i) disable iff (!rstn_i)
        (bus.instr_valid_o && !bus.instr_ready_i) |=>
        (bus.redirect_i || (bus.instr_valid_o && $stable(bus.instr_o) && $stable(bus.pc_o))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random scoreboard bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          MAXO     = 2;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic comp; } exp_t;

    logic clk;
    logic rstn;
    fetch_queue_if bus_if ();

    fetch_queue #(
        .DEPTH     (8),
        .MAX_OUTST (MAXO),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    pend_t       pend [$];
    exp_t        exp_q [$];
    exp_t        dir_q [$];
    logic [31:0] model_pc, model_req_addr, redir_target, prev_instr, prev_pc, first_req_addr;
    logic        redir_req, stall_prev;
    int          cyc, last_due, n_assert, n_fail, fire_cnt, first_req_cyc, first_valid_cyc;
    int          p_ready, p_iready, p_redir, lat_min, lat_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Golden PC walk over the memory image
    function automatic void fill_exp();
        exp_t        e;
        logic [15:0] hw;
        while (exp_q.size() < 16) begin
            hw   = mem_hw(model_pc);
            e.pc = model_pc;
            if (hw[1:0] == 2'b11) begin
                e.instr  = {mem_hw(model_pc + 32'd2), hw};
                e.comp   = 1'b0;
                model_pc = model_pc + 32'd4;
            end else begin
                e.instr  = {16'h0000, hw};
                e.comp   = 1'b1;
                model_pc = model_pc + 32'd2;
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic void start_stream(input logic [31:0] target);
        exp_q.delete();
        dir_q.delete();
        model_pc        = target & ~32'd1;
        model_req_addr  = target & ~32'd3;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        stall_prev      = 1'b0;
        fill_exp();
    endfunction

    function automatic void push_dir(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        dir_q.push_back(e);
    endfunction

    task automatic do_redirect(input logic [31:0] target);
        redir_req    = 1'b1;
        redir_target = target;
        start_stream(target);
    endtask

    // Called just after a falling edge; drives, samples at +1, returns at the next falling edge
    task automatic step();
        logic  redir, req_fire, out_fire;
        int    due;
        exp_t  e;
        exp_t  d;
        if (!redir_req && p_redir > 0 && $urandom_range(99) < p_redir)
            do_redirect(32'h8000_0000 | ($urandom_range(511) << 1));
        bus_if.redirect_i       = redir_req;
        bus_if.redirect_pc_i    = redir_target;
        redir                   = redir_req;
        redir_req               = 1'b0;
        bus_if.imem_req_ready_i = ($urandom_range(99) < p_ready);
        bus_if.instr_ready_i    = ($urandom_range(99) < p_iready);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus_if.imem_rsp_valid_i = 1'b1;
            bus_if.imem_rsp_data_i  = mem[pend[0].addr[9:2]];
            void'(pend.pop_front());
        end else begin
            bus_if.imem_rsp_valid_i = 1'b0;
            bus_if.imem_rsp_data_i  = 32'h0;
        end
        #1;
        if (redir) begin
            chk("redir_no_req", bus_if.imem_req_valid_o, 0);
            chk("redir_no_instr", bus_if.instr_valid_o, 0);
        end
        req_fire = bus_if.imem_req_valid_o && bus_if.imem_req_ready_i;
        if (req_fire) begin
            chk("req_addr", bus_if.imem_req_addr_o, model_req_addr);
            model_req_addr = model_req_addr + 32'd4;
            if (first_req_cyc < 0) begin
                first_req_cyc  = cyc;
                first_req_addr = bus_if.imem_req_addr_o;
            end
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{bus_if.imem_req_addr_o, due});
            chk("outst_limit", pend.size() <= MAXO, 1);
        end
        if (stall_prev && !redir) begin
            chk("stall_valid", bus_if.instr_valid_o, 1);
            chk("stall_instr", bus_if.instr_o, prev_instr);
            chk("stall_pc", bus_if.pc_o, prev_pc);
        end
        stall_prev = bus_if.instr_valid_o && !bus_if.instr_ready_i;
        prev_instr = bus_if.instr_o;
        prev_pc    = bus_if.pc_o;
        if (bus_if.instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        out_fire = bus_if.instr_valid_o && bus_if.instr_ready_i;
        if (out_fire) begin
            e = exp_q.pop_front();
            chk("sb_instr", bus_if.instr_o, e.instr);
            chk("sb_pc", bus_if.pc_o, e.pc);
            chk("sb_comp", bus_if.compressed_o, e.comp);
            if (dir_q.size() > 0) begin
                d = dir_q.pop_front();
                chk("dir_instr", bus_if.instr_o, d.instr);
                chk("dir_pc", bus_if.pc_o, d.pc);
                chk("dir_comp", bus_if.compressed_o, d.comp);
            end
            fill_exp();
            fire_cnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous assertion mid-cycle, release on a falling edge
    task automatic apply_reset(input bit randomize_mem);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_req_valid", bus_if.imem_req_valid_o, 0);
        chk("rst_req_addr", bus_if.imem_req_addr_o, RESET_PC);
        chk("rst_instr_valid", bus_if.instr_valid_o, 0);
        chk("rst_instr", bus_if.instr_o, 32'h0000_0013);
        chk("rst_pc", bus_if.pc_o, RESET_PC);
        chk("rst_comp", bus_if.compressed_o, 0);
        bus_if.redirect_i       = 1'b0;
        bus_if.imem_rsp_valid_i = 1'b0;
        bus_if.imem_req_ready_i = 1'b0;
        bus_if.instr_ready_i    = 1'b0;
        if (randomize_mem) for (int i = 0; i < 256; i++) mem[i] = $urandom;
        pend.delete();
        redir_req = 1'b0;
        start_stream(RESET_PC);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; last_due = 0; fire_cnt = 0;
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        redir_target = 32'h0; prev_instr = 32'h0; prev_pc = 32'h0; first_req_addr = 32'h0;
        rstn = 1'b0;
        bus_if.redirect_i = 1'b0; bus_if.redirect_pc_i = 32'h0;
        bus_if.imem_req_ready_i = 1'b0; bus_if.imem_rsp_valid_i = 1'b0;
        bus_if.imem_rsp_data_i = 32'h0; bus_if.instr_ready_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[64]  = 32'h0001_FFFF;
        for (int i = 128; i < 132; i++) mem[i] = 32'h0001_0001;
        mem[192] = 32'h0513_0001;
        mem[193] = 32'h0001_0000;
        @(negedge clk);

        // Reset values, then a sequential NOP stream at full throughput
        apply_reset(1'b0);
        push_dir(32'h0000_0013, 32'h8000_0000, 1'b0);
        push_dir(32'h0000_0013, 32'h8000_0004, 1'b0);
        push_dir(32'h0000_0013, 32'h8000_0008, 1'b0);
        repeat (3) step();
        chk("t1_first_req", first_req_addr, 32'h8000_0000);
        fire_cnt = 0;
        repeat (12) step();
        chk("t1_throughput", fire_cnt, 12);

        // Two compressed c.nop in one word
        do_redirect(32'h8000_0200);
        push_dir(32'h0000_0001, 32'h8000_0200, 1'b1);
        push_dir(32'h0000_0001, 32'h8000_0202, 1'b1);
        repeat (12) step();
        chk("t2_done", dir_q.size(), 0);

        // 32-bit instruction straddling two words
        do_redirect(32'h8000_0300);
        push_dir(32'h0000_0001, 32'h8000_0300, 1'b1);
        push_dir(32'h0000_0513, 32'h8000_0302, 1'b0);
        push_dir(32'h0000_0001, 32'h8000_0306, 1'b1);
        repeat (12) step();
        chk("t3_done", dir_q.size(), 0);

        // Redirect-to-valid latency with a 1-cycle memory
        repeat (4) step();
        do_redirect(32'h8000_0080);
        begin
            int n;
            n = cyc;
            repeat (6) step();
            chk("lat_req", first_req_cyc, n + 1);
            chk("lat_valid", first_valid_cyc, n + 3);
        end

        // Redirect with two requests in flight, into the upper halfword
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pend.size() != 2; i++) step();
        chk("t4_outst", pend.size(), 2);
        do_redirect(32'h8000_0102);
        push_dir(32'h0000_0001, 32'h8000_0102, 1'b1);
        lat_min = 1; lat_max = 1;
        repeat (15) step();
        chk("t4_req_addr", first_req_addr, 32'h8000_0100);
        chk("t4_done", dir_q.size(), 0);

        // Decode stall fills the queue and throttles requests
        p_iready = 0;
        repeat (10) step();
        chk("t5_req_stopped", bus_if.imem_req_valid_o, 0);
        chk("t5_valid_held", bus_if.instr_valid_o, 1);
        p_iready = 100;
        repeat (20) step();

        // Fetch address wraps through zero
        do_redirect(32'hFFFF_FFFC);
        push_dir(32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
        push_dir(32'h0000_0013, 32'h0000_0000, 1'b0);
        repeat (10) step();
        chk("wrap_done", dir_q.size(), 0);

        // Mid-burst reset, then random stalls, latency and redirects over random code
        apply_reset(1'b1);
        p_ready = 75; p_iready = 70; lat_min = 1; lat_max = 4; p_redir = 3;
        fire_cnt = 0;
        repeat (1500) step();
        p_redir = 0; p_iready = 100; p_ready = 100;
        repeat (40) step();
        chk("t6_progress", fire_cnt > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
